// File: rtl/seg7_scan_display_pkg.sv
// Shared constants and types for the 5-position multiplexed 7-segment display.
// Segment patterns are active-high, ordered {g,f,e,d,c,b,a}.
package seg7_scan_display_pkg;

  localparam int NUM_POS = 5;

  // Internal (active-high) level for "no anode driven".
  localparam logic [4:0] AN_OFF = 5'b00000;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_ERR_E = 7'h79;

  // Index n holds the pattern for digit n (element [9] is listed first).
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // One frame's worth of display inputs; digit[3] is the most significant.
  typedef struct packed {
    logic [3:0][3:0] digit;
    logic            minus;
    logic            lz;
  } snapshot_t;

endpackage

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; codes 10..15 show 'E'.
module bcd_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    seg = SEG_ERR_E;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexes four BCD digits plus a floating minus sign onto a 5-position
// common-anode display, with leading-zero blanking, fixed dp and guard blanking.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int DP_POS       = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       minus_flag,
  input  logic       lz_blank,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int             CW        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0]  GUARD_END = CW'(GUARD_CYCLES);
  localparam logic [2:0]     POS_LAST  = 3'(NUM_POS - 1);
  localparam logic [2:0]     DP_IDX    = 3'(DP_POS);
  localparam logic [4:0]     AN_MASK   = {5{ACTIVE_LOW}};
  localparam logic [6:0]     SEG_MASK  = {7{ACTIVE_LOW}};

  logic [CW-1:0] cnt;
  logic [2:0]    pos;
  logic          snap;
  snapshot_t     shadow;
  snapshot_t     view;
  logic [3:1]    blank;
  logic [2:0]    sign_pos;
  logic [3:0]    cur_digit;
  logic [6:0]    digit_seg;
  logic [4:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // The first cycle of every frame (including the one right after reset)
  // displays what is being captured, so the shadow is bypassed then.
  assign snap = (cnt == '0) && (pos == '0);
  assign view = snap ? {d3, d2, d1, d0, minus_flag, lz_blank} : shadow;

  // Blanking ripples down from d3 and stops at the decimal-point digit.
  always_comb begin
    blank    = '0;
    blank[3] = view.lz && (view.digit[3] == 4'd0) && (DP_POS < 3);
    blank[2] = blank[3] && (view.digit[2] == 4'd0) && (DP_POS < 2);
    blank[1] = blank[2] && (view.digit[1] == 4'd0) && (DP_POS < 1);
    sign_pos = blank[1] ? 3'd1 : blank[2] ? 3'd2 : blank[3] ? 3'd3 : 3'd4;
  end

  assign cur_digit = view.digit[pos[1:0]];

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (cur_digit),
    .seg (digit_seg)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b0;
    if (cnt >= GUARD_END) begin
      if (pos < sign_pos) begin
        an_nxt  = 5'b00001 << pos;
        seg_nxt = digit_seg;
        dp_nxt  = (pos == DP_IDX);
      end else if ((pos == sign_pos) && view.minus) begin
        an_nxt  = 5'b00001 << pos;
        seg_nxt = SEG_MINUS;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      pos         <= '0;
      shadow      <= '0;
      an          <= AN_OFF ^ AN_MASK;
      seg         <= SEG_BLANK ^ SEG_MASK;
      dp          <= ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap;
      if (snap) shadow <= view;
      an  <= an_nxt ^ AN_MASK;
      seg <= seg_nxt ^ SEG_MASK;
      dp  <= dp_nxt ^ ACTIVE_LOW;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        pos <= (pos == POS_LAST) ? 3'd0 : pos + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Display-side consumer of the stopwatch's BCD outputs: takes the four BCD digits plus sign flag and time-multiplexes them onto a 5-position common-anode 7-segment display. It handles leading-zero blanking, floating minus sign, fixed decimal point and anti-ghosting blanking. Inputs are snapshotted once per refresh frame so a digit roll-over never tears mid-scan. Sits between the stopwatch core and the board pins.

## Interface
- SLOT_CYCLES, 100000: clock cycles each digit position is driven (≥ 4).
- GUARD_CYCLES, 2: cycles at the start of each slot with all anodes off (< SLOT_CYCLES).
- DP_POS, 2: digit position (0..3) whose decimal point is lit.
- ACTIVE_LOW, 1: 1 = `an`, `seg`, `dp` are active-low at the pins.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- d3, d2, d1, d0  in  4 each  BCD digits, d3 most significant.
- minus_flag  in  1  value is negative; show '-'.
- lz_blank  in  1  enable leading-zero blanking.
- an  out  5  anode enables, position 0 = rightmost (d0), position 4 = leftmost.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point segment.
- frame_start  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Slot counter `cnt` counts 0..SLOT_CYCLES-1; on terminal count wraps to 0 and position index `pos` advances 0→1→2→3→4→0.
- Snapshot: when `pos` wraps 4→0 (and on the first cycle after reset release) register d3..d0, minus_flag, lz_blank into shadows; pulse frame_start same cycle. All display decisions use shadows only.
- Blanking (lz_blank=1): d3 blank if 0; d2 blank if d3 blank and 0; d1 blank if d2 blank and 0; d0 never. Any digit at position ≤ DP_POS is never blanked. lz_blank=0: no digit blank.
- Sign position S = (index of most significant unblanked digit) + 1; range 1..4. Position S shows '-' (segment g only) if minus_flag shadow = 1, else blank. Positions > S and blanked digits: all segments off, anode still not driven (anode off).
- BCD 10..15 decodes to 'E' (a,d,e,f,g).
- dp lit only when pos = DP_POS.
- During cnt < GUARD_CYCLES: an all off, seg/dp off.
- ACTIVE_LOW applied as final inversion on an, seg, dp.

## Timing
- Reset (async assert): cnt=0, pos=0, shadows=0, an/seg/dp = off levels (all 1 when ACTIVE_LOW), frame_start=0.
- After reset release: first cycle takes snapshot, frame_start=1; an/seg/dp registered, 1 cycle latency from (cnt,pos) to pins.
- Frame period = 5 × SLOT_CYCLES cycles; frame_start spacing identical.
- Input changes mid-frame invisible until next frame_start; input change in the snapshot cycle itself is captured.
- Reset asserted mid-slot: outputs off immediately (asynchronous), scan restarts at pos 0.

## Structure
- Shared package: segment pattern constants (digits 0–9, MINUS, ERR_E, BLANK), position count 5, anode-off constant.
- One sub-module: `bcd_to_seg7` (combinational, 4-bit BCD → 7-bit active-high pattern, 10–15 → 'E'). Scan counters, shadows, blanking and sign logic stay in the top.

## Test plan
- Reset held, then released with SLOT_CYCLES=8, GUARD_CYCLES=2, ACTIVE_LOW=1 → an=5'b11111 during reset; frame_start pulse cycle 1; frame_start every 40 cycles.
- Digits 1,2,3,4, minus=0, lz_blank=1 → positions 0..3 show 4,3,2,1, dp on pos 2 only, pos 4 anode off all frame.
- Digits 0,0,0,5, minus=1, lz_blank=1, DP_POS=2 → d3 blanked, pos 3 shows '-', pos 2 shows 0 with dp, pos 1 '0', pos 0 '5'.
- Digits 9,9,9,9 minus=1 → '-' on pos 4; d2 = 4'hC → pos 2 shows 'E' pattern.
- Change d0 from 3 to 7 mid-frame → old digit shown until next frame_start, new value after.
- Guard check: every slot's first 2 cycles an=5'b11111, seg=7'b1111111; assert reset mid-slot → outputs off same cycle, pos restarts at 0.
